// File: rtl/uart_mem_controller_if.sv
// uart_mem_controller_if: UART-side byte handshake plus status outputs of the memory command engine
interface uart_mem_controller_if;
  logic       received;
  logic [7:0] rx_byte;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       busy;
  logic [7:0] error_count;
  modport slave (
    input  received, rx_byte, is_transmitting,
    output transmit, tx_byte, busy, error_count
  );
  modport master (
    output received, rx_byte, is_transmitting,
    input  transmit, tx_byte, busy, error_count
  );
endinterface

// File: rtl/uart_mem_controller.sv
// uart_mem_controller: executes UART command frames (write/read/fill/status) against an on-chip byte RAM
module uart_mem_controller #(
  parameter int         ADDR_BYTES     = 2,
  parameter int         ADDR_BITS      = 10,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] CMD_WRITE      = 8'h01,
  parameter logic [7:0] CMD_READ       = 8'h02,
  parameter logic [7:0] CMD_FILL       = 8'h03,
  parameter logic [7:0] CMD_STATUS     = 8'h04,
  parameter logic [7:0] ACK            = 8'hAA,
  parameter logic [7:0] NAK            = 8'hEE
) (
  input logic clock,
  input logic reset,
  uart_mem_controller_if.slave bus
);
  localparam int MEM_DEPTH = 2 ** ADDR_BITS;
  typedef enum logic [3:0] {
    IDLE, GET_LEN, GET_ADDR, WR_DATA, FILL_VAL, FILL_RUN, RD_FETCH, RD_SEND, RD_GAP, RESP
  } state_t;
  logic [7:0] mem [MEM_DEPTH];
  state_t state;
  logic [7:0] cmd, fill_val, resp_byte, rd_data;
  logic resp_nak;
  logic [8:0] len_cnt;
  logic [ADDR_BITS-1:0] addr;
  logic [2:0] ab_cnt;
  logic [31:0] tmo;
  logic we, tx_free, timed, expired;
  always_comb begin
    we      = (state == WR_DATA && bus.received) || state == FILL_RUN;
    tx_free = !bus.is_transmitting && !bus.transmit;
    timed   = state inside {GET_LEN, GET_ADDR, WR_DATA, FILL_VAL};
    expired = TIMEOUT_CYCLES != 0 && tmo == 32'(TIMEOUT_CYCLES - 1);
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= state == FILL_RUN ? fill_val : bus.rx_byte;
    rd_data <= mem[addr];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      bus.transmit    <= 1'b0;
      bus.tx_byte     <= 8'h00;
      bus.error_count <= 8'h00;
      tmo             <= '0;
    end else begin
      bus.transmit <= 1'b0;
      tmo <= (!timed || bus.received) ? '0 : tmo + 32'd1;
      case (state)
        IDLE: if (bus.received) begin
          cmd <= bus.rx_byte;
          if (bus.rx_byte inside {CMD_WRITE, CMD_READ, CMD_FILL}) state <= GET_LEN;
          else begin
            resp_byte <= bus.rx_byte == CMD_STATUS ? bus.error_count : NAK;
            resp_nak  <= bus.rx_byte != CMD_STATUS;
            state     <= RESP;
          end
        end
        GET_LEN: if (bus.received) begin
          len_cnt <= {1'b0, bus.rx_byte};
          ab_cnt  <= '0;
          state   <= GET_ADDR;
        end
        GET_ADDR: if (bus.received) begin
          // big-endian shift; anything above ADDR_BITS falls off the top
          addr <= ADDR_BITS'({addr, bus.rx_byte});
          if (ab_cnt == 3'(ADDR_BYTES - 1))
            state <= cmd == CMD_WRITE ? WR_DATA : cmd == CMD_READ ? RD_FETCH : FILL_VAL;
          else ab_cnt <= ab_cnt + 3'd1;
        end
        WR_DATA: if (bus.received) begin
          addr <= addr + ADDR_BITS'(1);
          if (len_cnt == 9'd0) begin
            resp_byte <= ACK;
            resp_nak  <= 1'b0;
            state     <= RESP;
          end else len_cnt <= len_cnt - 9'd1;
        end
        FILL_VAL: if (bus.received) begin
          fill_val <= bus.rx_byte;
          state    <= FILL_RUN;
        end
        FILL_RUN: begin
          addr <= addr + ADDR_BITS'(1);
          if (len_cnt == 9'd0) begin
            resp_byte <= ACK;
            resp_nak  <= 1'b0;
            state     <= RESP;
          end else len_cnt <= len_cnt - 9'd1;
        end
        RD_FETCH: state <= RD_SEND;
        RD_SEND: if (tx_free) begin
          bus.transmit <= 1'b1;
          bus.tx_byte  <= rd_data;
          state        <= RD_GAP;
        end
        RD_GAP: if (len_cnt == 9'd0) state <= IDLE;
        else begin
          len_cnt <= len_cnt - 9'd1;
          addr    <= addr + ADDR_BITS'(1);
          state   <= RD_FETCH;
        end
        RESP: if (tx_free) begin
          bus.transmit <= 1'b1;
          bus.tx_byte  <= resp_byte;
          if (resp_nak && bus.error_count != 8'hFF) bus.error_count <= bus.error_count + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // an idle gap inside a frame overrides whatever the case decided
      if (timed && !bus.received && expired) begin
        resp_byte <= NAK;
        resp_nak  <= 1'b1;
        state     <= RESP;
      end
    end
  end
endmodule

// File: tb/tb_uart_mem_controller.sv
// tb_uart_mem_controller: table-driven frames plus timeout, reset-abort and saturation sequences
module tb_uart_mem_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic hold_tx = 1'b0;
  always #5 clock = ~clock;
  uart_mem_controller_if bus();
  uart_mem_controller #(.ADDR_BYTES(2), .ADDR_BITS(10), .TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  typedef struct {
    logic [63:0] in;
    int          n_in;
    logic [63:0] ex;
    int          n_ex;
  } vec_t;
  vec_t vecs[15];
  logic [7:0] rxq[$];
  int checks = 0, failures = 0, cyc = 0, last_pulse = -10, tx_left = 0, last_strobe = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    bus.is_transmitting = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (bus.transmit === 1'b1) begin
        chk("tx_while_busy", {31'd0, bus.is_transmitting}, 0);
        chk("tx_spacing", {31'd0, cyc - last_pulse >= 2}, 1);
        rxq.push_back(bus.tx_byte);
        last_pulse = cyc;
        tx_left = 4;
      end else if (tx_left > 0) tx_left--;
      bus.is_transmitting = hold_tx || tx_left != 0;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    bus.received = 1'b1;
    bus.rx_byte = b;
    @(posedge clock); #1;
    bus.received = 1'b0;
    last_strobe = cyc;
  endtask
  task automatic wait_quiet(input int n, input string name);
    int t = 0;
    while (t < 3000 && (rxq.size() < n || bus.busy)) begin
      @(negedge clock);
      t++;
    end
    repeat (4) @(negedge clock);
    chk({name, "_done"}, {31'd0, t < 3000}, 1);
  endtask
  task automatic apply_vec(input vec_t v, input string name);
    rxq.delete();
    for (int i = 0; i < v.n_in; i++) send_byte(v.in[8*(v.n_in-1-i) +: 8]);
    wait_quiet(v.n_ex, name);
    chk({name, "_count"}, rxq.size(), v.n_ex);
    for (int i = 0; i < v.n_ex && i < rxq.size(); i++)
      chk(name, {24'd0, rxq[i]}, {24'd0, v.ex[8*(v.n_ex-1-i) +: 8]});
  endtask
  initial begin
    vec_t v;
    int diff;
    vecs[0]  = '{64'h04,             1, 64'h00,           1};
    vecs[1]  = '{64'h01020010424344, 7, 64'hAA,           1};
    vecs[2]  = '{64'h02020010,       4, 64'h424344,       3};
    vecs[3]  = '{64'h010103FF1122,   6, 64'hAA,           1};
    vecs[4]  = '{64'h02000000,       4, 64'h22,           1};
    vecs[5]  = '{64'h020103FF,       4, 64'h1122,         2};
    vecs[6]  = '{64'h0100001F77,     5, 64'hAA,           1};
    vecs[7]  = '{64'h0100002499,     5, 64'hAA,           1};
    vecs[8]  = '{64'h030300205A,     5, 64'hAA,           1};
    vecs[9]  = '{64'h0205001F,       4, 64'h775A5A5A5A99, 6};
    vecs[10] = '{64'h010003003C,     5, 64'hAA,           1};
    vecs[11] = '{64'h03FF0200A5,     5, 64'hAA,           1};
    vecs[12] = '{64'h020102FF,       4, 64'hA53C,         2};
    vecs[13] = '{64'h7F,             1, 64'hEE,           1};
    vecs[14] = '{64'h04,             1, 64'h01,           1};
    bus.received = 1'b0;
    bus.rx_byte = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_transmit", {31'd0, bus.transmit}, 0);
    chk("rst_tx_byte", {24'd0, bus.tx_byte}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_error_count", {24'd0, bus.error_count}, 0);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) apply_vec(vecs[k], $sformatf("vec%0d", k));
    chk("err_after_nak", {24'd0, bus.error_count}, 1);
    // frame stalls after the first address byte
    rxq.delete();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_quiet(1, "timeout");
    chk("timeout_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("timeout_byte", {24'd0, rxq[0]}, 32'hEE);
    diff = last_pulse - last_strobe;
    chk("timeout_min_delay", {31'd0, diff >= 50}, 1);
    chk("timeout_max_delay", {31'd0, diff <= 56}, 1);
    chk("err_after_timeout", {24'd0, bus.error_count}, 2);
    v = '{64'h01000100C3, 5, 64'hAA, 1}; apply_vec(v, "post_timeout_wr");
    v = '{64'h02000100,   4, 64'hC3, 1}; apply_vec(v, "post_timeout_rd");
    v = '{64'h04,         1, 64'h02, 1}; apply_vec(v, "status2");
    // reset while a read waits on a busy transmitter
    hold_tx = 1'b1;
    repeat (2) @(negedge clock);
    rxq.delete();
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
    repeat (5) @(negedge clock);
    chk("stalled_busy", {31'd0, bus.busy}, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_transmit", {31'd0, bus.transmit}, 0);
    chk("abort_error_count", {24'd0, bus.error_count}, 0);
    repeat (3) @(negedge clock);
    hold_tx = 1'b0;
    repeat (20) @(negedge clock);
    chk("abort_no_tx", rxq.size(), 0);
    v = '{64'h02020010, 4, 64'h424344, 3}; apply_vec(v, "after_abort_rd");
    // 256 NAKs must pin the counter at FF
    for (int k = 0; k < 256; k++) begin
      rxq.delete();
      send_byte(8'h7F);
      wait_quiet(1, "sat_nak");
    end
    chk("err_saturated", {24'd0, bus.error_count}, 32'hFF);
    v = '{64'h04, 1, 64'hFF, 1}; apply_vec(v, "status_sat");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
